// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles every handshake and memory-bus signal of the unified memory arbiter.
//   CPU port    : cpu_req/cpu_we/cpu_addr/cpu_wdata in, cpu_ack/cpu_rdata/cpu_stall out
//   Loader port : ldr_req/ldr_we/ldr_addr/ldr_wdata/ldr_lock in, ldr_ack/ldr_rdata out
//   Memory port : mem_en/mem_we/mem_addr/mem_din out, mem_dout in (sync read, 1-cycle)
//   Status      : grant_owner (00 none, 01 CPU, 10 loader)
// Modport slave is the arbiter's view; modport master is the view of the
// requesters and memory that surround it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_lock;
  logic              ldr_ack;
  logic [DATA_W-1:0] ldr_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  logic [1:0]        grant_owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
    output ldr_ack, ldr_rdata,
    output mem_en, mem_we, mem_addr, mem_din,
    input  mem_dout,
    output grant_owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
    input  ldr_ack, ldr_rdata,
    input  mem_en, mem_we, mem_addr, mem_din,
    output mem_dout,
    input  grant_owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single synchronous-read unified memory between the CPU and the
// loader/debug port. Each access runs IDLE (arbitrate) -> ISSUE (memory
// access) -> RESP (ack + read data). Round-robin between the two requesters,
// with a loader bus lock and a CPU anti-starvation override.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - mem_port_arbiter_if.slave: CPU port, loader port, memory port and
//          grant_owner status (see the interface file for the signal list)
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 15
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} stateT;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_LDR  = 2'b10;
  localparam int         CNT_W    = $clog2(STARVE_MAX + 1);

  stateT             state, nextState;
  logic [1:0]        owner, lastOwner;
  logic              latWe;
  logic [ADDR_W-1:0] latAddr;
  logic [DATA_W-1:0] latData;
  logic [CNT_W-1:0]  starveCnt;
  logic [DATA_W-1:0] cpuRdataQ, ldrRdataQ;
  logic              starved, cpuWins, ldrWins;
  logic              cpuRespRd, ldrRespRd;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Arbitration, next state and registered-state output decode
  always_comb begin
    nextState   = state;
    bus.mem_en  = 1'b0;
    bus.mem_we  = 1'b0;
    bus.cpu_ack = 1'b0;
    bus.ldr_ack = 1'b0;
    starved     = (starveCnt == CNT_W'(STARVE_MAX));
    cpuWins     = 1'b0;
    ldrWins     = 1'b0;

    if (bus.cpu_req && bus.ldr_req)
      // Tie: the CPU wins when starved, or when the loader went last and is
      // not holding its lock; otherwise the loader keeps/takes the port.
      cpuWins = starved || (lastOwner == OWN_LDR && !bus.ldr_lock);
    else
      cpuWins = bus.cpu_req;
    ldrWins = bus.ldr_req && !cpuWins;

    case (state)
      IDLE:  if (bus.cpu_req || bus.ldr_req) nextState = ISSUE;
      ISSUE: begin
        bus.mem_en = 1'b1;
        bus.mem_we = latWe;
        nextState  = RESP;
      end
      RESP: begin
        bus.cpu_ack = (owner == OWN_CPU);
        bus.ldr_ack = (owner == OWN_LDR);
        nextState   = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign cpuRespRd = (state == RESP) && (owner == OWN_CPU) && !latWe;
  assign ldrRespRd = (state == RESP) && (owner == OWN_LDR) && !latWe;

  // Read data is forwarded straight from memory during the ack cycle, then
  // held in the per-port register until that port's next read ack.
  assign bus.cpu_rdata   = cpuRespRd ? bus.mem_dout : cpuRdataQ;
  assign bus.ldr_rdata   = ldrRespRd ? bus.mem_dout : ldrRdataQ;
  assign bus.mem_addr    = latAddr;
  assign bus.mem_din     = latData;
  assign bus.grant_owner = (state == IDLE) ? OWN_NONE : owner;
  assign bus.cpu_stall   = bus.cpu_req && !((state == RESP) && (owner == OWN_CPU));

  // Grant latch, fairness history, starvation counter, read-data hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN_NONE;
      lastOwner <= OWN_LDR;
      latWe     <= 1'b0;
      latAddr   <= '0;
      latData   <= '0;
      starveCnt <= '0;
      cpuRdataQ <= '0;
      ldrRdataQ <= '0;
    end else begin
      if (state == IDLE && (cpuWins || ldrWins)) begin
        owner     <= cpuWins ? OWN_CPU : OWN_LDR;
        lastOwner <= cpuWins ? OWN_CPU : OWN_LDR;
        latWe     <= cpuWins ? bus.cpu_we    : bus.ldr_we;
        latAddr   <= cpuWins ? bus.cpu_addr  : bus.ldr_addr;
        latData   <= cpuWins ? bus.cpu_wdata : bus.ldr_wdata;
      end
      if (state == IDLE && cpuWins)
        starveCnt <= '0;
      else if (state == IDLE && ldrWins && bus.cpu_req && !starved)
        starveCnt <= starveCnt + CNT_W'(1);
      if (cpuRespRd) cpuRdataQ <= bus.mem_dout;
      if (ldrRespRd) ldrRdataQ <= bus.mem_dout;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and access sequencer for the single unified instruction/data memory of the multicycle CPU. It shares the one synchronous-read memory port between the CPU (fetch and load/store through the IorD path) and a loader/debug port used for program download and memory inspection. Each access is a three-state sequence: decide, issue, respond. The CPU is stalled while its request is pending. Fairness is round-robin, with an optional loader lock and a CPU anti-starvation override.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 15, number of consecutive lost arbitrations after which the CPU wins regardless of ldr_lock.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req.
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req.
- cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  CPU read data.
- cpu_stall  out  1  cpu_req pending and not completing this cycle.
- ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/ADDR_W/DATA_W  loader request; same rules as the CPU port.
- ldr_lock  in  1  loader requests bus retention across consecutive accesses.
- ldr_ack  out  1  loader completion pulse.
- ldr_rdata  out  DATA_W  loader read data.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  DATA_W  memory write data.
- mem_dout  in  DATA_W  memory read data; valid one cycle after the mem_en edge.
- grant_owner  out  2  00 none, 01 CPU, 10 loader.

## Operation
- States:
  - IDLE: arbitration.
  - ISSUE: memory access.
  - RESP: completion.
- IDLE: at the edge, if any req is high, latch the winner's owner, we, addr and wdata, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE:
  - mem_en=1; mem_we=latched we; mem_addr and mem_din come from the latched fields.
  - Always go to RESP.
- RESP:
  - Owner's ack=1.
  - For a read, the owner's rdata equals mem_dout this cycle and is registered at the edge. It holds until that port's next read ack.
  - A write ack leaves rdata unchanged.
  - Always go to IDLE.
- Arbitration in IDLE:
  - Only one req high: that requester wins.
  - Both high: the non-last owner wins (round-robin), except when ldr_lock=1 and the last owner was the loader; then the loader wins.
  - Override: if starve_cnt == STARVE_MAX, the CPU wins unconditionally.
- last_owner updates on every grant. Its reset value is loader, so the CPU wins the first tie.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, when cpu_req=1 in IDLE and the loader wins.
  - Clears on any CPU grant.
- A req still high in IDLE after its ack is a new request. Requesters must drop req or present new fields in the cycle after ack.
- cpu_stall = cpu_req & ~(state==RESP & owner==CPU). This is combinational.
- mem_en, mem_we and grant_owner are decoded from registered state only, with no input-to-output path.
- Outside ISSUE: mem_en=0 and mem_we=0; mem_addr and mem_din hold the latched values.

## Timing
- Latency: req sampled at the edge ending IDLE cycle N, then ISSUE in cycle N+1, then ack in cycle N+2.
- Throughput: one access per 3 cycles per requester when uncontended.
- Reset values:
  - state=IDLE, last_owner=loader, starve_cnt=0.
  - cpu_ack=0, ldr_ack=0.
  - cpu_rdata=0, ldr_rdata=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
  - grant_owner=00.
  - cpu_stall=cpu_req.
- Reset mid-ISSUE: mem_en and mem_we drop immediately (asynchronous). No write commits and no ack is given; the requester re-requests.
- Reset mid-RESP: the ack is truncated; rdata is not updated.
- Simultaneous requests are resolved only in IDLE. A request arriving during ISSUE or RESP waits for the next IDLE.

## Test plan
- **CPU read:** memory[0x10]=0xDEADBEEF; cpu_req read 0x10 from cycle 0.
  - Cycle 1: mem_en=1, mem_addr=0x10, grant_owner=01.
  - Cycle 2: cpu_ack=1, cpu_rdata=0xDEADBEEF, cpu_stall=0.
  - cpu_stall=1 in cycles 0–1.
- **Tie after reset:** both reqs held from cycle 0 with ldr_lock=0.
  - Grants go CPU, loader, CPU, loader.
  - Acks arrive in cycles 2, 5, 8, 11.
- **Starvation override:** ldr_lock=1, continuous loader writes, cpu_req=1.
  - The loader wins 15 consecutive arbitrations, then the CPU is granted.
  - starve_cnt returns to 0.
- **Write then read:** loader writes 0x12345678 to 0x20, then the CPU reads 0x20.
  - cpu_rdata=0x12345678.
  - ldr_rdata is unchanged by the write ack.
- **Reset during ISSUE of a CPU write:** assert rst in that cycle.
  - mem_en and mem_we go to 0 the same cycle; no cpu_ack; grant_owner=00; memory contents unchanged.
  - After release, the repeated request completes in 3 cycles.
